// File: rtl/stripes_mac_ctrl.sv
// Stripes MAC sequencer: walks weight bits MSB->LSB per 16-lane tile, drives
// the bit-serial MAC, then drains its 2-stage pipe and holds the result.
// Ports: clk, reset (sync, active-low), start_valid/start_ready + cfg_num_tiles,
//   cfg_w_prec job handshake; stall freezes issue; buf_rd_en/buf_rd_tile buffer
//   read; mac_en/mac_load_accum/mac_column_idx/mac_is_msb MAC controls; busy,
//   cfg_err pulse, result_valid/result_ready result handshake.
// Option: STRIPES_CTRL_PERF_EN adds perf_busy_cyc/perf_stall_cyc counters.
module stripes_mac_ctrl #(
    parameter int TILE_W = 8,
    parameter int PREC_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [TILE_W-1:0] cfg_num_tiles,
    input  logic [PREC_W-1:0] cfg_w_prec,
    input  logic              stall,
    output logic              buf_rd_en,
    output logic [TILE_W-1:0] buf_rd_tile,
    output logic              mac_en,
    output logic              mac_load_accum,
    output logic [2:0]        mac_column_idx,
    output logic              mac_is_msb,
    output logic              busy,
    output logic              cfg_err,
`ifdef STRIPES_CTRL_PERF_EN
    output logic [31:0]       perf_busy_cyc,
    output logic [31:0]       perf_stall_cyc,
`endif
    output logic              result_valid,
    input  logic              result_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [TILE_W-1:0] tile_q, tile_d;
    logic [TILE_W-1:0] last_tile_q, last_tile_d;
    logic [2:0]        bit_q, bit_d;
    logic [2:0]        top_bit_q, top_bit_d;
    logic              seen_q, seen_d;
    logic              loaded_q, loaded_d;
    logic              cfg_err_q, cfg_err_d;

    logic              prec_bad;
    logic [2:0]        prec_top;
    logic              issue;

    // Precision 0 or above 8 falls back to full 8-bit weights.
    assign prec_bad = (cfg_w_prec == '0) || (32'(cfg_w_prec) > 32'd8);
    assign prec_top = prec_bad ? 3'd7 : 3'(cfg_w_prec - PREC_W'(1));

    // A stalled cycle issues nothing: the buffer cannot serve it this cycle.
    assign issue = (state_q == S_ISSUE) && !stall;

    assign start_ready  = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign buf_rd_en    = issue;
    assign mac_en       = issue || (state_q == S_DRAIN);
    assign result_valid = (state_q == S_DONE);
    assign cfg_err      = cfg_err_q;

    // The first product reaches the accumulator one MAC-enabled cycle after
    // it is issued; that cycle seeds the accumulator from accum_prev.
    assign mac_load_accum = mac_en && seen_q && !loaded_q;

    assign mac_column_idx = (state_q == S_ISSUE) ? bit_q : 3'd0;
    assign mac_is_msb     = (state_q == S_ISSUE) && (bit_q == top_bit_q);
    assign buf_rd_tile    = (state_q == S_ISSUE) ? tile_q : '0;

    always_comb begin
        state_d     = state_q;
        tile_d      = tile_q;
        last_tile_d = last_tile_q;
        bit_d       = bit_q;
        top_bit_d   = top_bit_q;
        seen_d      = seen_q;
        loaded_d    = loaded_q || mac_load_accum;
        cfg_err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    cfg_err_d = prec_bad || (cfg_num_tiles == '0);
                    if (cfg_num_tiles != '0) begin
                        state_d     = S_ISSUE;
                        tile_d      = '0;
                        last_tile_d = cfg_num_tiles - TILE_W'(1);
                        bit_d       = prec_top;
                        top_bit_d   = prec_top;
                        seen_d      = 1'b0;
                        loaded_d    = 1'b0;
                    end
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    seen_d = 1'b1;
                    if (bit_q == 3'd0) begin
                        if (tile_q == last_tile_q) begin
                            state_d = S_DRAIN;
                        end else begin
                            tile_d = tile_q + TILE_W'(1);
                            bit_d  = top_bit_q;
                        end
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (result_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            tile_q      <= '0;
            last_tile_q <= '0;
            bit_q       <= 3'd0;
            top_bit_q   <= 3'd0;
            seen_q      <= 1'b0;
            loaded_q    <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tile_q      <= tile_d;
            last_tile_q <= last_tile_d;
            bit_q       <= bit_d;
            top_bit_q   <= top_bit_d;
            seen_q      <= seen_d;
            loaded_q    <= loaded_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

`ifdef STRIPES_CTRL_PERF_EN
    logic [31:0] perf_busy_q, perf_busy_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_busy_d  = perf_busy_q;
        perf_stall_d = perf_stall_q;
        if (busy && (perf_busy_q != '1)) begin
            perf_busy_d = perf_busy_q + 32'd1;
        end
        if ((state_q == S_ISSUE) && stall && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_busy_q  <= perf_busy_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_busy_cyc  = perf_busy_q;
    assign perf_stall_cyc = perf_stall_q;
`endif

endmodule
